line_merge_wcb: RTL and testbench

- Single-entry write-combining line buffer; parametrised successor to the combinational word-into-line byte merge.
- Accepts byte-enabled word stores and allocates a line on the first store; the line is read from the data array with the pending bytes preserved.
- Later same-line stores merge in; the merged line is written back on eviction, flush or (optionally) idle timeout.
- Sits between the PE store path and the L1 data array read/write ports.

---
 rtl/line_merge_wcb_if.sv | 32 +++
 rtl/line_merge_wcb.sv | 82 ++++++++
 tb/tb_line_merge_wcb.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/line_merge_wcb_if.sv
// line_merge_wcb_if: store (st_*), line read (rd_*) and line write (wr_*) ports of line_merge_wcb; slave = buffer side, master = environment side
interface line_merge_wcb_if #(
  parameter int LINE_W = 256,
  parameter int WORD_W = 32,
  parameter int ADDR_W = 27
);
  localparam int SEL_W = $clog2(LINE_W / WORD_W);
  localparam int BE_W = WORD_W / 8;
  logic st_valid;
  logic st_ready;
  logic [ADDR_W-1:0] st_addr;
  logic [SEL_W-1:0] st_sel;
  logic [BE_W-1:0] st_be;
  logic [WORD_W-1:0] st_wd;
  logic rd_req;
  logic rd_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic rd_valid;
  logic [LINE_W-1:0] rd_data;
  logic wr_valid;
  logic wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [LINE_W-1:0] wr_data;
  modport slave (
    input st_valid, st_addr, st_sel, st_be, st_wd, rd_ready, rd_valid, rd_data, wr_ready,
    output st_ready, rd_req, rd_addr, wr_valid, wr_addr, wr_data
  );
  modport master (
    output st_valid, st_addr, st_sel, st_be, st_wd, rd_ready, rd_valid, rd_data, wr_ready,
    input st_ready, rd_req, rd_addr, wr_valid, wr_addr, wr_data
  );
endinterface

// File: rtl/line_merge_wcb.sv
// line_merge_wcb: single-entry write-combining line buffer; ports clk, rst (sync, active-high), flush, empty, bus (slave: st_* stores, rd_* line fill, wr_* line writeback); `define WCB_TIMEOUT_EN adds an idle-timeout drain after TIMEOUT HOLD cycles
module line_merge_wcb #(
  parameter int LINE_W = 256,
  parameter int WORD_W = 32,
  parameter int ADDR_W = 27,
  parameter int TIMEOUT = 16
) (
  input logic clk,
  input logic rst,
  input logic flush,
  output logic empty,
  line_merge_wcb_if.slave bus
);
  localparam int BE_W = WORD_W / 8;
  localparam int LBE_W = LINE_W / 8;
  typedef enum logic [1:0] {IDLE, FILL, HOLD, DRAIN} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] tag;
  logic [LINE_W-1:0] line_q, line_n;
  logic [LBE_W-1:0] mask_q, mask_n;
  logic rd_pend, hit, acc, tmo;
  assign hit = bus.st_addr == tag;
  assign bus.st_ready = !rst && (state == IDLE || ((state == FILL || state == HOLD) && hit));
  assign acc = bus.st_valid && bus.st_ready;
  assign bus.rd_req = rd_pend;
  assign bus.rd_addr = tag;
  assign bus.wr_valid = state == DRAIN;
  assign bus.wr_addr = tag;
  assign bus.wr_data = line_q;
  assign empty = state == IDLE;
`ifdef WCB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  logic [CNT_W-1:0] idle_cnt;
  assign tmo = idle_cnt == CNT_W'(TIMEOUT - 1);
  always_ff @(posedge clk)
    if (rst || acc || state != HOLD) idle_cnt <= '0;
    else if (!tmo) idle_cnt <= idle_cnt + 1'b1;
`else
  assign tmo = TIMEOUT < 0;
`endif
  always_comb begin
    mask_n = state == IDLE ? '0 : mask_q;
    line_n = line_q;
    if (state == FILL && bus.rd_valid) begin
      for (int i = 0; i < LBE_W; i++)
        if (!mask_q[i]) line_n[i*8 +: 8] = bus.rd_data[i*8 +: 8];
      mask_n = '1;
    end
    if (acc)
      for (int b = 0; b < BE_W; b++)
        if (bus.st_be[b]) begin
          line_n[(int'(bus.st_sel) * BE_W + b) * 8 +: 8] = bus.st_wd[b*8 +: 8];
          mask_n[int'(bus.st_sel) * BE_W + b] = 1'b1;
        end
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (acc && |bus.st_be) state_n = FILL;
      FILL: if (bus.rd_valid) state_n = HOLD;
      HOLD: if ((bus.st_valid && !hit) || flush || tmo) state_n = DRAIN;
      DRAIN: if (bus.wr_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mask_q <= '0;
      rd_pend <= 1'b0;
      tag <= '0;
    end else begin
      state <= state_n;
      mask_q <= mask_n;
      if (state == IDLE && state_n == FILL) begin
        tag <= bus.st_addr;
        rd_pend <= 1'b1;
      end else if (bus.rd_ready) rd_pend <= 1'b0;
    end
    line_q <= line_n;
  end
endmodule

// File: tb/tb_line_merge_wcb.sv
// tb_line_merge_wcb: directed stimulus for line_merge_wcb checked against a fill-then-replay-stores reference model plus literal expectations
module tb_line_merge_wcb;
  localparam int LINE_W = 256;
  localparam int WORD_W = 32;
  localparam int ADDR_W = 27;
  localparam int TIMEOUT = 16;
  localparam int BE_W = WORD_W / 8;
  localparam int SEL_W = $clog2(LINE_W / WORD_W);
  localparam int WORDS = LINE_W / WORD_W;
  typedef struct {
    int sel;
    logic [BE_W-1:0] be;
    logic [WORD_W-1:0] wd;
  } st_t;
  logic clk = 0;
  logic rst = 1;
  logic flush = 0;
  logic empty;
  int checks = 0;
  int failures = 0;
  int rd_hs = 0;
  int hs0;
  logic has_line = 0;
  logic fill_seen = 0;
  logic chk_en = 0;
  logic [ADDR_W-1:0] m_tag = '0;
  logic [LINE_W-1:0] m_fill = '0;
  logic [LINE_W-1:0] e;
  st_t sq[$];
  st_t s_tmp;
  line_merge_wcb_if #(.LINE_W(LINE_W), .WORD_W(WORD_W), .ADDR_W(ADDR_W)) bus ();
  line_merge_wcb #(.LINE_W(LINE_W), .WORD_W(WORD_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .empty(empty),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  function automatic logic [LINE_W-1:0] replay();
    logic [LINE_W-1:0] l = m_fill;
    foreach (sq[i])
      for (int b = 0; b < BE_W; b++)
        if (sq[i].be[b]) l[(sq[i].sel * BE_W + b) * 8 +: 8] = sq[i].wd[b*8 +: 8];
    return l;
  endfunction
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_empty", empty, !has_line);
      if (bus.rd_req) begin
        chk("m_rd_addr", {has_line, bus.rd_addr}, {1'b1, m_tag});
        if (bus.rd_ready) rd_hs++;
      end
      if (bus.wr_valid) begin
        chk("m_wr_addr", {has_line, bus.wr_addr}, {1'b1, m_tag});
        chk("m_wr_data", bus.wr_data, replay());
      end
      if (bus.st_valid && bus.st_ready && has_line) chk("m_acc_hit", bus.st_addr, m_tag);
    end
    if (rst) begin
      has_line = 0;
      fill_seen = 0;
    end else begin
      if (has_line && !fill_seen && bus.rd_valid) begin
        m_fill = bus.rd_data;
        fill_seen = 1;
      end
      if (bus.wr_valid && bus.wr_ready) has_line = 0;
      if (bus.st_valid && bus.st_ready) begin
        if (!has_line && bus.st_be != 0) begin
          has_line = 1;
          m_tag = bus.st_addr;
          fill_seen = 0;
          sq.delete();
        end
        if (has_line) begin
          s_tmp.sel = int'(bus.st_sel);
          s_tmp.be = bus.st_be;
          s_tmp.wd = bus.st_wd;
          sq.push_back(s_tmp);
        end
      end
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic drive_st(input logic v, input logic [ADDR_W-1:0] a, input int sel, input logic [BE_W-1:0] be, input logic [WORD_W-1:0] wd);
    bus.st_valid = v;
    bus.st_addr = a;
    bus.st_sel = SEL_W'(sel);
    bus.st_be = be;
    bus.st_wd = wd;
  endtask
  task automatic alloc_fill(input logic [ADDR_W-1:0] a);
    drive_st(1, a, 3, 4'hF, 32'hC0DE0000);
    cyc();
    drive_st(0, '0, 0, '0, '0);
    cyc();
    bus.rd_valid = 1;
    bus.rd_data = {WORDS{32'h33333333}};
    cyc();
    bus.rd_valid = 0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
  initial begin
    bus.rd_valid = 0;
    bus.rd_data = '0;
    bus.rd_ready = 1;
    bus.wr_ready = 1;
    drive_st(1, 27'h10, 2, 4'b0011, 32'hAABBCCDD);
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1;
    @(negedge clk);
    chk("rst_st_ready", bus.st_ready, 0);
    chk("rst_empty", empty, 1);
    chk("rst_rd_req", bus.rd_req, 0);
    chk("rst_wr_valid", bus.wr_valid, 0);
    cyc();
    rst = 0;
    @(negedge clk);
    chk("idle_st_ready", bus.st_ready, 1);
    chk("idle_empty", empty, 1);
    cyc();
    drive_st(0, '0, 0, '0, '0);
    @(negedge clk);
    chk("alloc_rd_req", bus.rd_req, 1);
    chk("alloc_rd_addr", bus.rd_addr, 27'h10);
    chk("alloc_empty", empty, 0);
    cyc();
    @(negedge clk);
    chk("rd_req_drop", bus.rd_req, 0);
    cyc();
    cyc();
    bus.rd_valid = 1;
    bus.rd_data = {WORDS{32'h11111111}};
    cyc();
    bus.rd_valid = 0;
    drive_st(1, 27'h10, 2, 4'b0000, 32'hFFFFFFFF);
    @(negedge clk);
    chk("be0_st_ready", bus.st_ready, 1);
    chk("hold_wr_valid", bus.wr_valid, 0);
    cyc();
    drive_st(0, '0, 0, '0, '0);
    flush = 1;
    @(negedge clk);
    chk("flush_same_cycle", bus.wr_valid, 0);
    cyc();
    flush = 0;
    e = {WORDS{32'h11111111}};
    e[95:64] = 32'h1111CCDD;
    @(negedge clk);
    chk("flush_wr_valid", bus.wr_valid, 1);
    chk("flush_wr_addr", bus.wr_addr, 27'h10);
    chk("flush_wr_data", bus.wr_data, e);
    cyc();
    @(negedge clk);
    chk("post_flush_empty", empty, 1);
    drive_st(1, 27'h10, 2, 4'b0011, 32'hAABBCCDD);
    @(negedge clk);
    chk("alloc2_st_ready", bus.st_ready, 1);
    cyc();
    drive_st(1, 27'h10, 0, 4'hF, 32'h01020304);
    @(negedge clk);
    chk("fill_hit0", bus.st_ready, 1);
    cyc();
    drive_st(1, 27'h10, 7, 4'b1000, 32'hFF000000);
    bus.rd_valid = 1;
    for (int i = 0; i < WORDS; i++) bus.rd_data[i*32 +: 32] = 32'hA0A0A0A0 ^ i;
    @(negedge clk);
    chk("fill_hit7", bus.st_ready, 1);
    cyc();
    bus.rd_valid = 0;
    bus.wr_ready = 0;
    drive_st(1, 27'h20, 1, 4'hF, 32'hDEADBEEF);
    @(negedge clk);
    chk("miss_st_ready", bus.st_ready, 0);
    chk("miss_wr_valid", bus.wr_valid, 0);
    for (int i = 0; i < WORDS; i++) e[i*32 +: 32] = 32'hA0A0A0A0 ^ i;
    e[31:0] = 32'h01020304;
    e[95:64] = 32'hA0A0CCDD;
    e[255:224] = 32'hFFA0A0A7;
    for (int k = 0; k < 4; k++) begin
      cyc();
      @(negedge clk);
      chk("stall_wr_valid", bus.wr_valid, 1);
      chk("stall_wr_addr", bus.wr_addr, 27'h10);
      chk("stall_wr_data", bus.wr_data, e);
      chk("stall_st_ready", bus.st_ready, 0);
    end
    cyc();
    bus.wr_ready = 1;
    @(negedge clk);
    chk("drain_hs_wr_valid", bus.wr_valid, 1);
    cyc();
    bus.rd_ready = 0;
    @(negedge clk);
    chk("post_drain_accept", bus.st_ready, 1);
    chk("post_drain_empty", empty, 1);
    cyc();
    drive_st(0, '0, 0, '0, '0);
    flush = 1;
    @(negedge clk);
    chk("evict_rd_req", bus.rd_req, 1);
    chk("evict_rd_addr", bus.rd_addr, 27'h20);
    for (int k = 1; k < 5; k++) begin
      cyc();
      @(negedge clk);
      chk("bp_rd_req", bus.rd_req, 1);
      chk("bp_rd_addr", bus.rd_addr, 27'h20);
      chk("fill_flush_deferred", bus.wr_valid, 0);
    end
    cyc();
    bus.rd_ready = 1;
    hs0 = rd_hs;
    @(negedge clk);
    chk("bp_hs_rd_req", bus.rd_req, 1);
    cyc();
    bus.rd_ready = 0;
    @(negedge clk);
    chk("bp_rd_req_drop", bus.rd_req, 0);
    chk("bp_one_hs", rd_hs, hs0 + 1);
    chk("bp_wr_valid", bus.wr_valid, 0);
    cyc();
    bus.rd_valid = 1;
    bus.rd_data = {WORDS{32'h5A5A5A5A}};
    cyc();
    bus.rd_valid = 0;
    bus.rd_ready = 1;
    @(negedge clk);
    chk("hold_flush_wr_valid0", bus.wr_valid, 0);
    cyc();
    flush = 0;
    @(negedge clk);
    chk("bp_wr_valid1", bus.wr_valid, 1);
    chk("bp_word1", bus.wr_data[63:32], 32'hDEADBEEF);
    chk("bp_word0", bus.wr_data[31:0], 32'h5A5A5A5A);
    cyc();
    drive_st(1, 27'h40, 0, 4'b0001, 32'h000000AA);
    @(negedge clk);
    chk("r_alloc_st_ready", bus.st_ready, 1);
    cyc();
    drive_st(0, '0, 0, '0, '0);
    @(negedge clk);
    chk("r_rd_req", bus.rd_req, 1);
    cyc();
    rst = 1;
    cyc();
    rst = 0;
    @(negedge clk);
    chk("r_empty", empty, 1);
    chk("r_rd_req0", bus.rd_req, 0);
    chk("r_wr_valid0", bus.wr_valid, 0);
    cyc();
    bus.rd_valid = 1;
    bus.rd_data = '1;
    cyc();
    bus.rd_valid = 0;
    flush = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stray_empty", empty, 1);
      chk("stray_wr_valid", bus.wr_valid, 0);
      chk("stray_rd_req", bus.rd_req, 0);
      cyc();
    end
    flush = 0;
`ifdef WCB_TIMEOUT_EN
    bus.wr_ready = 0;
    alloc_fill(27'h50);
    for (int k = 0; k <= 16; k++) begin
      @(negedge clk);
      chk("tmo_wr_valid", bus.wr_valid, k == 16);
      if (k < 16) cyc();
    end
    cyc();
    bus.wr_ready = 1;
    cyc();
    bus.wr_ready = 0;
    alloc_fill(27'h60);
    for (int k = 0; k <= 27; k++) begin
      if (k == 10) drive_st(1, 27'h60, 5, 4'h3, 32'h0000BEEF);
      if (k == 11) drive_st(0, '0, 0, '0, '0);
      @(negedge clk);
      chk("tmo_restart_wr_valid", bus.wr_valid, k >= 27);
      if (k == 10) chk("tmo_hit_st_ready", bus.st_ready, 1);
      if (k < 27) cyc();
    end
    cyc();
    bus.wr_ready = 1;
    cyc();
    cyc();
`else
    alloc_fill(27'h50);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      chk("no_tmo_wr_valid", bus.wr_valid, 0);
      cyc();
    end
    flush = 1;
    cyc();
    flush = 0;
    @(negedge clk);
    chk("no_tmo_flush_wr_valid", bus.wr_valid, 1);
    cyc();
`endif
    @(negedge clk);
    chk("end_empty", empty, 1);
`ifdef WCB_TIMEOUT_EN
    chk("rd_hs_total", rd_hs, 6);
`else
    chk("rd_hs_total", rd_hs, 5);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
